// File: rtl/sb3320_run_motor.sv
// Line-follow and node-turn motor controller: debounced 3-bit line sensing,
// steering PWM, halt at nodes and commanded straight/left/right/U-turn manoeuvres.
module sb3320_run_motor #(
    parameter int unsigned PWM_PERIOD   = 50000,
    parameter int unsigned DUTY_FWD     = 35000,
    parameter int unsigned DUTY_TURN    = 30000,
    parameter int unsigned DEBOUNCE_CYC = 2500,
    parameter int unsigned CLEAR_CYC    = 12500000,
    parameter int unsigned TURN_TIMEOUT = 150000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       sensor_l,
    input  logic       sensor_m,
    input  logic       sensor_r,
    input  logic       turn_start,
    input  logic [2:0] turn_dir,
    output logic [2:0] turn,
    output logic       l_motor,
    output logic       r_motor,
    output logic       gndl,
    output logic       motor_stopped,
    output logic       turn_done
);

    localparam int unsigned PW   = $clog2(PWM_PERIOD);
    localparam int unsigned DW   = $clog2(PWM_PERIOD + 1);
    localparam int unsigned DBW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TMAX = (CLEAR_CYC > TURN_TIMEOUT) ? CLEAR_CYC : TURN_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX);

    localparam logic [DW-1:0] C_DUTY_FWD  = DW'(DUTY_FWD);
    localparam logic [DW-1:0] C_DUTY_TURN = DW'(DUTY_TURN);

    localparam logic [2:0] DIR_FWD   = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_XTRM  = 3'b100;

    localparam logic [2:0] TURN_STOP  = 3'b000;
    localparam logic [2:0] TURN_FWD   = 3'b001;
    localparam logic [2:0] TURN_LEFT  = 3'b010;
    localparam logic [2:0] TURN_RIGHT = 3'b011;

    typedef enum logic [2:0] {
        ST_FOLLOW,
        ST_HALT,
        ST_CLEAR,
        ST_SEEK,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_cand;
    logic [2:0]       r_pat;
    logic [2:0]       r_last_ns;
    logic [2:0]       r_dir;
    logic [DBW-1:0]   r_db_cnt;
    logic [PW-1:0]    r_pwm;
    logic [TW-1:0]    r_timer;
    logic             r_mask;
    logic             r_halt_arm;
    logic             r_phase;
    logic             r_l_motor;
    logic             r_r_motor;
    logic             r_gndl;
    logic             r_stopped;
    logic             r_done;

    logic             w_stable;
    logic             w_accept;
    logic [2:0]       w_class;
    logic [2:0]       w_dir_eff;
    logic [DW-1:0]    w_duty_l;
    logic [DW-1:0]    w_duty_r;
    logic             w_gndl;
    logic             w_stopped;
    logic             w_done;

    assign w_stable = (r_db_cnt == DBW'(DEBOUNCE_CYC));
    assign w_accept = turn_start && (r_state == ST_HALT) && r_halt_arm;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_pat    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= {sensor_l, sensor_m, sensor_r};
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_db_cnt <= DBW'(1);
            end else if (!w_stable) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_stable) begin
                r_pat <= r_cand;
            end
        end
    end

    // Line lost (000) falls back to the last non-stop classification.
    always_comb begin
        w_class = r_last_ns;
        case (r_pat)
            3'b010, 3'b101: w_class = TURN_FWD;
            3'b100, 3'b110: w_class = TURN_LEFT;
            3'b001, 3'b011: w_class = TURN_RIGHT;
            3'b111:         w_class = TURN_STOP;
            default:        w_class = r_last_ns;
        endcase
    end

    assign turn = w_class;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_last_ns <= TURN_FWD;
        end else if (w_class != TURN_STOP) begin
            r_last_ns <= w_class;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FOLLOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FOLLOW: begin
                if (w_class == TURN_STOP && !r_mask) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (w_accept) begin
                    case (turn_dir)
                        DIR_FWD, DIR_LEFT, DIR_RIGHT: w_state_nxt = ST_CLEAR;
                        DIR_XTRM:                     w_state_nxt = ST_SEEK;
                        default:                      w_state_nxt = ST_HALT;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (r_timer == TW'(CLEAR_CYC - 1)) begin
                    w_state_nxt = (r_dir == DIR_FWD) ? ST_DONE : ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (r_timer == TW'(TURN_TIMEOUT - 1) || (r_phase && r_pat[1])) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:   w_state_nxt = ST_FOLLOW;
            default:   w_state_nxt = ST_FOLLOW;
        endcase
    end

    // Outputs are decoded from the next state so the registered drive changes on the
    // same edge as the state, keeping halt latency to one cycle after adoption.
    assign w_dir_eff = (r_state == ST_HALT) ? turn_dir : r_dir;

    always_comb begin
        w_duty_l  = '0;
        w_duty_r  = '0;
        w_gndl    = 1'b0;
        w_stopped = 1'b0;
        w_done    = 1'b0;
        case (w_state_nxt)
            ST_FOLLOW: begin
                case (w_class)
                    TURN_LEFT:  w_duty_r = C_DUTY_FWD;
                    TURN_RIGHT: w_duty_l = C_DUTY_FWD;
                    default: begin
                        w_duty_l = C_DUTY_FWD;
                        w_duty_r = C_DUTY_FWD;
                    end
                endcase
            end
            ST_HALT:  w_stopped = 1'b1;
            ST_CLEAR: begin
                w_duty_l = C_DUTY_FWD;
                w_duty_r = C_DUTY_FWD;
            end
            ST_SEEK: begin
                case (w_dir_eff)
                    DIR_LEFT:  w_duty_r = C_DUTY_TURN;
                    DIR_RIGHT: w_duty_l = C_DUTY_TURN;
                    DIR_XTRM: begin
                        w_duty_l = C_DUTY_TURN;
                        w_duty_r = C_DUTY_TURN;
                        w_gndl   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_dir      <= '0;
            r_timer    <= '0;
            r_mask     <= 1'b0;
            r_halt_arm <= 1'b0;
            r_phase    <= 1'b0;
        end else begin
            r_halt_arm <= (r_state == ST_HALT);
            if (w_accept) begin
                r_dir <= turn_dir;
            end
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_state == ST_CLEAR || r_state == ST_SEEK) begin
                r_timer <= r_timer + 1'b1;
            end
            // Mask node detection after a manoeuvre until the node pattern is gone.
            if (r_state == ST_DONE) begin
                r_mask <= 1'b1;
            end else if (r_pat != 3'b111) begin
                r_mask <= 1'b0;
            end
            if (r_state != ST_SEEK) begin
                r_phase <= 1'b0;
            end else if (!r_pat[1]) begin
                r_phase <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm     <= '0;
            r_l_motor <= 1'b0;
            r_r_motor <= 1'b0;
            r_gndl    <= 1'b0;
            r_stopped <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (r_pwm == PW'(PWM_PERIOD - 1)) begin
                r_pwm <= '0;
            end else begin
                r_pwm <= r_pwm + 1'b1;
            end
            r_l_motor <= (DW'(r_pwm) < w_duty_l);
            r_r_motor <= (DW'(r_pwm) < w_duty_r);
            r_gndl    <= w_gndl;
            r_stopped <= w_stopped;
            r_done    <= w_done;
        end
    end

    assign l_motor       = r_l_motor;
    assign r_motor       = r_r_motor;
    assign gndl          = r_gndl;
    assign motor_stopped = r_stopped;
    assign turn_done     = r_done;

endmodule

// File: tb/tb_sb3320_run_motor.sv
// Bench for sb3320_run_motor: directed sensor/turn vectors, node events checked by a
// queue-driven monitor, PWM duty and flags measured over fixed windows.
module tb_sb3320_run_motor;

    localparam int EV_HALT = 1;
    localparam int EV_DONE = 2;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_l = 1'b0;
    logic       sensor_m = 1'b0;
    logic       sensor_r = 1'b0;
    logic       turn_start = 1'b0;
    logic [2:0] turn_dir = 3'b000;
    logic [2:0] turn;
    logic       l_motor;
    logic       r_motor;
    logic       gndl;
    logic       motor_stopped;
    logic       turn_done;

    sb3320_run_motor #(
        .PWM_PERIOD  (10),
        .DUTY_FWD    (7),
        .DUTY_TURN   (5),
        .DEBOUNCE_CYC(3),
        .CLEAR_CYC   (20),
        .TURN_TIMEOUT(200)
    ) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .sensor_l     (sensor_l),
        .sensor_m     (sensor_m),
        .sensor_r     (sensor_r),
        .turn_start   (turn_start),
        .turn_dir     (turn_dir),
        .turn         (turn),
        .l_motor      (l_motor),
        .r_motor      (r_motor),
        .gndl         (gndl),
        .motor_stopped(motor_stopped),
        .turn_done    (turn_done)
    );

    always #5 clk_50 = ~clk_50;

    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_q[$];
    string name_q[$];
    logic  prev_ms = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void ev(input int kind);
        int    k;
        string nm;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, 0);
        end else begin
            k  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, "_kind"}, kind, k);
            if (kind == EV_HALT) begin
                chk({nm, "_turn"}, int'(turn), 0);
                chk({nm, "_motors"}, int'({l_motor, r_motor}), 0);
            end else begin
                chk({nm, "_gndl"}, int'(gndl), 0);
                chk({nm, "_stopped"}, int'(motor_stopped), 0);
            end
        end
    endfunction

    // Monitor: halts (motor_stopped rising) and turn_done pulses pop the scoreboard.
    always @(negedge clk_50) begin
        if (!rst_n) begin
            prev_ms <= 1'b0;
        end else begin
            if (motor_stopped && !prev_ms) ev(EV_HALT);
            if (turn_done) ev(EV_DONE);
            prev_ms <= motor_stopped;
        end
    end

    function automatic void expect_ev(input int kind, input string nm);
        exp_q.push_back(kind);
        name_q.push_back(nm);
    endfunction

    task automatic set_s(input logic [2:0] p);
        {sensor_l, sensor_m, sensor_r} = p;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic pulse(input logic [2:0] d);
        @(posedge clk_50);
        #1;
        turn_dir   = d;
        turn_start = 1'b1;
        @(posedge clk_50);
        #1;
        turn_start = 1'b0;
    endtask

    task automatic measure(input int n, output int cl, output int cr, output int cg, output int cs);
        cl = 0; cr = 0; cg = 0; cs = 0;
        repeat (n) begin
            @(negedge clk_50);
            cl += int'(l_motor);
            cr += int'(r_motor);
            cg += int'(gndl);
            cs += int'(motor_stopped);
        end
    endtask

    task automatic wait_ms(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_50);
            if (motor_stopped) seen = 1'b1;
        end
        chk({nm, "_reached"}, int'(seen), 1);
        @(posedge clk_50);
        #1;
    endtask

    task automatic run_to_done(input int bound, output int nf, output int nl, output int nr,
                               output int ng, output bit ok);
        nf = 0; nl = 0; nr = 0; ng = 0; ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk_50);
            if (turn_done) begin
                ok = 1'b1;
            end else begin
                if (!motor_stopped) nf++;
                nl += int'(l_motor);
                nr += int'(r_motor);
                ng += int'(gndl);
            end
        end
    endtask

    task automatic reach_node(input string nm);
        set_s(3'b101);
        cyc(10);
        expect_ev(EV_HALT, nm);
        set_s(3'b111);
        wait_ms(nm);
        cyc(2);
    endtask

    initial begin
        int cl, cr, cg, cs, nf;
        bit ok;

        set_s(3'b000);
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        chk("reset_turn", int'(turn), 1);
        chk("reset_outs", int'({l_motor, r_motor, gndl, motor_stopped, turn_done}), 0);
        @(posedge clk_50);
        #1;
        rst_n = 1'b1;

        set_s(3'b010);
        pulse(3'b001);
        cyc(10);
        chk("fwd_turn", int'(turn), 1);
        measure(10, cl, cr, cg, cs);
        chk("fwd_l_duty", cl, 7);
        chk("fwd_r_duty", cr, 7);
        chk("fwd_gndl_stopped", cg + cs, 0);

        set_s(3'b110);
        cyc(10);
        chk("left_turn_code", int'(turn), 2);
        measure(10, cl, cr, cg, cs);
        chk("left_l_duty", cl, 0);
        chk("left_r_duty", cr, 7);

        set_s(3'b011);
        cyc(10);
        chk("right_turn_code", int'(turn), 3);
        measure(10, cl, cr, cg, cs);
        chk("right_l_duty", cl, 7);
        chk("right_r_duty", cr, 0);

        set_s(3'b000);
        cyc(10);
        chk("lost_holds_right", int'(turn), 3);

        set_s(3'b101);
        cyc(10);
        chk("pat101_fwd", int'(turn), 1);

        set_s(3'b111);
        repeat (2) @(posedge clk_50);
        #1;
        set_s(3'b101);
        cyc(10);
        measure(10, cl, cr, cg, cs);
        chk("glitch111_no_halt", cs, 0);
        chk("glitch111_turn", int'(turn), 1);

        reach_node("halt1");
        measure(10, cl, cr, cg, cs);
        chk("halt_motors", cl + cr, 0);
        chk("halt_stopped", cs, 10);
        chk("halt_turn", int'(turn), 0);

        pulse(3'b000);
        cyc(5);
        pulse(3'b110);
        cyc(5);
        measure(10, cl, cr, cg, cs);
        chk("dir000_stays_halted", cs, 10);

        expect_ev(EV_DONE, "fwd_done");
        pulse(3'b001);
        run_to_done(100, nf, cl, cr, cg, ok);
        chk("fwd_done_seen", int'(ok), 1);
        chk("fwd_clear_cycles", nf, 20);
        chk("fwd_clear_l", cl, 14);
        chk("fwd_clear_r", cr, 14);
        cyc(10);
        measure(10, cl, cr, cg, cs);
        chk("fwd_no_rehalt", cs, 0);
        chk("fwd_masked_turn", int'(turn), 0);

        reach_node("halt2");
        expect_ev(EV_DONE, "left_done");
        pulse(3'b010);
        cyc(25);
        pulse(3'b100);
        measure(10, cl, cr, cg, cs);
        chk("seekL_l", cl, 0);
        chk("seekL_r", cr, 5);
        chk("seekL_gndl_ignored_start", cg, 0);
        chk("seekL_stopped", cs, 0);
        set_s(3'b101);
        cyc(6);
        set_s(3'b111);
        run_to_done(60, nf, cl, cr, cg, ok);
        chk("left_done_seen", int'(ok), 1);
        cyc(15);
        measure(10, cl, cr, cg, cs);
        chk("left_no_rehalt", cs, 0);

        reach_node("halt3");
        expect_ev(EV_DONE, "uturn_done");
        pulse(3'b100);
        run_to_done(400, nf, cl, cr, cg, ok);
        chk("uturn_done_seen", int'(ok), 1);
        chk("uturn_timeout_cycles", nf, 200);
        chk("uturn_gndl_cycles", cg, 200);
        chk("uturn_l", cl, 100);
        chk("uturn_r", cr, 100);
        @(negedge clk_50);
        chk("uturn_gndl_after", int'(gndl), 0);

        reach_node("halt4");
        pulse(3'b100);
        cyc(30);
        @(negedge clk_50);
        chk("seekX_gndl", int'(gndl), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({l_motor, r_motor, gndl, motor_stopped, turn_done}), 0);
        chk("async_reset_turn", int'(turn), 1);
        set_s(3'b010);
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        chk("post_reset_turn", int'(turn), 1);
        measure(10, cl, cr, cg, cs);
        chk("post_reset_l", cl, 7);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
